int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Three-source prioritized, nesting interrupt controller with a 3-deep EPC stack.
// Emits one-cycle redirect (int_jump) and return (ret_jump) pulses to the fetch stage.
module int_ctrl #(
    parameter logic [31:0] VEC0 = 32'h0000_0100,
    parameter logic [31:0] VEC1 = 32'h0000_0200,
    parameter logic [31:0] VEC2 = 32'h0000_0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  int_req,
    input  logic        int_en,
    input  logic        take_ok,
    input  logic [31:0] resume_pc,
    input  logic        eret,
    output logic        int_jump,
    output logic        ret_jump,
    output logic [31:0] int_addr,
    output logic [2:0]  pending,
    output logic [2:0]  in_service,
    output logic [1:0]  depth
);

    logic [2:0]  req_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  in_service_q, in_service_d;
    logic [1:0]  depth_q, depth_d;
    logic [1:0]  holdoff_q, holdoff_d;
    logic [31:0] stack_q [3];
    logic [31:0] stack_d [3];
    logic        int_jump_q, ret_jump_q;
    logic [31:0] int_addr_q, int_addr_d;

    logic [2:0]  req_edge;
    logic        cand_valid, lvl_valid;
    logic [1:0]  cand_idx, lvl_idx;
    logic        accept, pop;
    logic [2:0]  accept_mask, top_mask;
    logic [31:0] vec_addr, pop_addr;

    assign req_edge = int_req & ~req_q;

    // Highest set pending bit is the candidate.
    always_comb begin
        cand_valid = 1'b1;
        cand_idx   = 2'd0;
        if (pending_q[2])      cand_idx = 2'd2;
        else if (pending_q[1]) cand_idx = 2'd1;
        else if (pending_q[0]) cand_idx = 2'd0;
        else                   cand_valid = 1'b0;
    end

    // Highest set in_service bit is the current priority level.
    always_comb begin
        lvl_valid = 1'b1;
        lvl_idx   = 2'd0;
        top_mask  = 3'b000;
        if (in_service_q[2]) begin
            lvl_idx  = 2'd2;
            top_mask = 3'b100;
        end else if (in_service_q[1]) begin
            lvl_idx  = 2'd1;
            top_mask = 3'b010;
        end else if (in_service_q[0]) begin
            lvl_idx  = 2'd0;
            top_mask = 3'b001;
        end else begin
            lvl_valid = 1'b0;
        end
    end

    // eret always wins over acceptance in the same cycle.
    assign accept = cand_valid && (!lvl_valid || (cand_idx > lvl_idx)) && int_en && take_ok
                    && !eret && (depth_q != 2'd3) && (holdoff_q == 2'd0);
    assign pop    = eret && (depth_q != 2'd0) && take_ok && (holdoff_q == 2'd0);

    always_comb begin
        accept_mask = 3'b000;
        vec_addr    = VEC0;
        unique case (cand_idx)
            2'd2:    begin accept_mask = 3'b100; vec_addr = VEC2; end
            2'd1:    begin accept_mask = 3'b010; vec_addr = VEC1; end
            default: begin accept_mask = 3'b001; vec_addr = VEC0; end
        endcase
        if (!accept) accept_mask = 3'b000;
    end

    always_comb begin
        pop_addr = stack_q[0];
        unique case (depth_q)
            2'd2:    pop_addr = stack_q[1];
            2'd3:    pop_addr = stack_q[2];
            default: pop_addr = stack_q[0];
        endcase
    end

    always_comb begin
        // A fresh edge in the accepting cycle keeps the bit pending.
        pending_d    = (pending_q & ~accept_mask) | req_edge;
        in_service_d = in_service_q;
        depth_d      = depth_q;
        int_addr_d   = int_addr_q;
        for (int i = 0; i < 3; i++) stack_d[i] = stack_q[i];

        if (accept) begin
            in_service_d = in_service_q | accept_mask;
            depth_d      = depth_q + 2'd1;
            int_addr_d   = vec_addr;
            for (int i = 0; i < 3; i++) begin
                if (depth_q == i[1:0]) stack_d[i] = resume_pc;
            end
        end else if (pop) begin
            in_service_d = in_service_q & ~top_mask;
            depth_d      = depth_q - 2'd1;
            int_addr_d   = pop_addr;
        end

        if (accept || pop)          holdoff_d = 2'd2;
        else if (holdoff_q != 2'd0) holdoff_d = holdoff_q - 2'd1;
        else                        holdoff_d = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q        <= 3'b000;
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            depth_q      <= 2'd0;
            holdoff_q    <= 2'd0;
            int_jump_q   <= 1'b0;
            ret_jump_q   <= 1'b0;
            int_addr_q   <= 32'd0;
            for (int i = 0; i < 3; i++) stack_q[i] <= 32'd0;
        end else begin
            req_q        <= int_req;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            depth_q      <= depth_d;
            holdoff_q    <= holdoff_d;
            int_jump_q   <= accept;
            ret_jump_q   <= pop;
            int_addr_q   <= int_addr_d;
            for (int i = 0; i < 3; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign int_jump   = int_jump_q;
    assign ret_jump   = ret_jump_q;
    assign int_addr   = int_addr_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign depth      = depth_q;

endmodule
